muxl_param: RTL



---
 rtl/muxl_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/muxl_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : muxl_param
// Brief    : Parametrised lane multiplexer. Each NUM_IN-lane beat is sliced
//            into RATIO = NUM_IN/NUM_OUT consecutive NUM_OUT-lane slots.
//            It has a one-beat skid buffer and output backpressure.
//            Optional macro MUXL_SKIP_IDLE_EN: accepted beats whose per-lane
//            valids are all zero are dropped instead of sliced.
// Revision : 1.0 - initial release
// ============================================================================
module muxl_param #(
  parameter int WIDTH   = 8,
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 2,
  localparam int RATIO  = NUM_IN / NUM_OUT,
  localparam int PW     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic                     clk_2f,
  input  logic                     reset_L,
  input  logic [NUM_IN*WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]        in_valid,
  input  logic                     in_push,
  output logic                     in_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]       out_valid,
  output logic                     out_active,
  output logic [PW-1:0]            out_phase,
  input  logic                     out_ready
);

  localparam logic [PW-1:0] C_LAST_PH = PW'(RATIO - 1);

  // The input lane count must split evenly over the output lanes.
  if (NUM_IN % NUM_OUT != 0) begin : g_ratio_check
    $error("muxl_param: NUM_IN must be a multiple of NUM_OUT");
  end

  // Beat being sliced, the skid beat behind it, and the output stage.
  logic [NUM_IN*WIDTH-1:0]  cur_data_q, cur_data_d;
  logic [NUM_IN-1:0]        cur_valid_q, cur_valid_d;
  logic                     cur_full_q, cur_full_d;
  logic [PW-1:0]            cur_ph_q, cur_ph_d;
  logic [NUM_IN*WIDTH-1:0]  buf_data_q, buf_data_d;
  logic [NUM_IN-1:0]        buf_valid_q, buf_valid_d;
  logic                     buf_full_q, buf_full_d;
  logic                     in_ready_q, in_ready_d;
  logic [NUM_OUT*WIDTH-1:0] out_data_q, out_data_d;
  logic [NUM_OUT-1:0]       out_valid_q, out_valid_d;
  logic                     out_active_q, out_active_d;
  logic [PW-1:0]            out_phase_q, out_phase_d;

  logic                     adv;
  logic                     accept;
  logic                     take;
  logic                     consume;
  logic                     cur_free;
  logic [NUM_OUT*WIDTH-1:0] slice_data;
  logic [NUM_OUT-1:0]       slice_valid;

  // The output stage may load a new slot when it is empty or being taken.
  assign adv     = !out_active_q || out_ready;
  assign accept  = in_push && in_ready_q;
  assign consume = adv && cur_full_q && (cur_ph_q == C_LAST_PH);
  assign cur_free = !cur_full_q || consume;

`ifdef MUXL_SKIP_IDLE_EN
  // All-invalid beats are handshaken but never stored.
  assign take = accept && (|in_valid);
`else
  assign take = accept;
`endif

  // Select slice cur_ph: output lane j carries input lane j*RATIO + cur_ph.
  always_comb begin
    slice_data  = '0;
    slice_valid = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      slice_data[j*WIDTH +: WIDTH] = cur_data_q[(j*RATIO + int'(cur_ph_q))*WIDTH +: WIDTH];
      slice_valid[j]               = cur_valid_q[j*RATIO + int'(cur_ph_q)];
    end
  end

  // Next-state for beat storage, phase counter and output stage.
  always_comb begin
    cur_data_d   = cur_data_q;
    cur_valid_d  = cur_valid_q;
    cur_full_d   = cur_full_q;
    cur_ph_d     = cur_ph_q;
    buf_data_d   = buf_data_q;
    buf_valid_d  = buf_valid_q;
    buf_full_d   = buf_full_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_active_d = out_active_q;
    out_phase_d  = out_phase_q;

    if (adv) begin
      if (cur_full_q) begin
        out_data_d   = slice_data;
        out_valid_d  = slice_valid;
        out_active_d = 1'b1;
        out_phase_d  = cur_ph_q;
        cur_ph_d     = (cur_ph_q == C_LAST_PH) ? '0 : cur_ph_q + PW'(1);
      end else begin
        out_active_d = 1'b0;
        out_valid_d  = '0;
      end
    end

    // Refill cur from buf first, then straight from the input; otherwise
    // an accepted beat parks in buf (which is empty whenever in_ready is 1).
    if (cur_free) begin
      if (buf_full_q) begin
        cur_data_d  = buf_data_q;
        cur_valid_d = buf_valid_q;
        cur_full_d  = 1'b1;
        buf_full_d  = 1'b0;
      end else if (take) begin
        cur_data_d  = in_data;
        cur_valid_d = in_valid;
        cur_full_d  = 1'b1;
      end else begin
        cur_full_d  = 1'b0;
      end
    end else if (take) begin
      buf_data_d  = in_data;
      buf_valid_d = in_valid;
      buf_full_d  = 1'b1;
    end

    in_ready_d = !buf_full_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_2f) begin
    if (!reset_L) begin
      cur_data_q   <= '0;
      cur_valid_q  <= '0;
      cur_full_q   <= 1'b0;
      cur_ph_q     <= '0;
      buf_data_q   <= '0;
      buf_valid_q  <= '0;
      buf_full_q   <= 1'b0;
      in_ready_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      out_active_q <= 1'b0;
      out_phase_q  <= '0;
    end else begin
      cur_data_q   <= cur_data_d;
      cur_valid_q  <= cur_valid_d;
      cur_full_q   <= cur_full_d;
      cur_ph_q     <= cur_ph_d;
      buf_data_q   <= buf_data_d;
      buf_valid_q  <= buf_valid_d;
      buf_full_q   <= buf_full_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_active_q <= out_active_d;
      out_phase_q  <= out_phase_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_active = out_active_q;
  assign out_phase  = out_phase_q;

endmodule
`default_nettype wire
